// File: rtl/riscv_mem_pkg.sv
// Shared MMIO map, STATUS layout and register decode
// for the hart data-side memory subsystem.
package riscv_mem_pkg;

  localparam logic [31:0] OFF_TXDATA = 32'h0000_0000;
  localparam logic [31:0] OFF_STATUS = 32'h0000_0004;
  localparam logic [31:0] OFF_CYC_LO = 32'h0000_0008;
  localparam logic [31:0] OFF_CYC_HI = 32'h0000_000C;

  localparam int ST_FULL  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_CNT   = 4;
  localparam int ST_FAULT = 8;
  localparam int ST_OVF   = 9;

  typedef enum logic [2:0] {
    REG_TXDATA,
    REG_STATUS,
    REG_CYC_LO,
    REG_CYC_HI,
    REG_NONE
  } mmio_reg_t;

  function automatic mmio_reg_t mmio_decode(
    input logic [31:0] off
  );
    mmio_reg_t r;
    r = REG_NONE;
    unique case (off)
      OFF_TXDATA: r = REG_TXDATA;
      OFF_STATUS: r = REG_STATUS;
      OFF_CYC_LO: r = REG_CYC_LO;
      OFF_CYC_HI: r = REG_CYC_HI;
      default:    r = REG_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/riscv_data_mem_tx_fifo.sv
// Small power-of-two FIFO; a push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module riscv_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     push_ok_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [WIDTH-1:0]         head_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty_o   = (cnt_q == '0);
  assign full_o    = (cnt_q == (PW+1)'(DEPTH));
  assign do_pop    = pop_i & ~empty_o;
  assign do_push   = push_i & (~full_o | do_pop);
  assign push_ok_o = do_push;
  assign count_o   = cnt_q;
  assign head_o    = empty_o ? '0 : mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q + PW'(do_push);
    rd_d  = rd_q + PW'(do_pop);
    cnt_d = cnt_q + (PW+1)'(do_push)
                  - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/riscv_data_mem.sv
// Data-side memory: word RAM plus MMIO window with console
// TX FIFO, sticky status flags and a 64-bit cycle counter.
module riscv_data_mem
  import riscv_mem_pkg::*;
#(
  parameter int              XLEN       = 32,
  parameter int              MEM_WORDS  = 1024,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'h8000_0000,
  parameter int              FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_write,
  output logic [XLEN-1:0] mem_read,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            fault
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [XLEN-1:0] RAM_BYTES =
    XLEN'(MEM_WORDS * 4);

  logic [XLEN-1:0] ram_q [MEM_WORDS];
  logic [XLEN-1:0] off;
  logic [AW-1:0]   idx;
  mmio_reg_t       sel;
  logic            mis, ram_hit, mmio_hit, bad;
  logic            push, pop, push_ok, full, empty;
  logic            stw, rd_lo;
  logic [CW-1:0]   count;
  logic            fault_q, fault_d;
  logic            ovf_q, ovf_d;
  logic [63:0]     cyc_q, cyc_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     status;

  assign mis      = |mem_addr[1:0];
  assign ram_hit  = mem_addr < RAM_BYTES;
  assign mmio_hit = mem_addr >= MMIO_BASE;
  assign off      = mem_addr - MMIO_BASE;
  assign idx      = mem_addr[2 +: AW];
  assign sel      = mmio_hit ? mmio_decode(32'(off))
                             : REG_NONE;
  // misaligned MMIO offsets never decode, so they land in REG_NONE
  assign bad      = mis
                  | (~ram_hit & ~mmio_hit)
                  | (mmio_hit & (sel == REG_NONE));

  assign push  = rst & mem_write & (sel == REG_TXDATA);
  assign pop   = tx_valid & tx_ready;
  assign stw   = mem_write & (sel == REG_STATUS);
  assign rd_lo = ~mem_write & (sel == REG_CYC_LO);

  riscv_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .data_i    (mem_data[7:0]),
    .pop_i     (pop),
    .full_o    (full),
    .empty_o   (empty),
    .push_ok_o (push_ok),
    .count_o   (count),
    .head_o    (tx_data)
  );

  assign tx_valid = ~empty;
  assign fault    = fault_q;

  always_ff @(posedge clk) begin
    if (rst & mem_write & ram_hit & ~mis)
      ram_q[idx] <= mem_data;
  end

  always_comb begin
    status = '0;
    status[ST_FULL]     = full;
    status[ST_EMPTY]    = empty;
    status[ST_CNT +: 4] = 4'(count);
    status[ST_FAULT]    = fault_q;
    status[ST_OVF]      = ovf_q;
  end

  // a clear written to STATUS beats a set in the same cycle
  always_comb begin
    fault_d = (fault_q | bad)
            & ~(stw & mem_data[ST_FAULT]);
    ovf_d   = (ovf_q | (push & ~push_ok))
            & ~(stw & mem_data[ST_OVF]);
    cyc_d   = cyc_q + 64'd1;
    hi_d    = rd_lo ? cyc_q[63:32] : hi_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fault_q <= 1'b0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
      hi_q    <= '0;
    end else begin
      fault_q <= fault_d;
      ovf_q   <= ovf_d;
      cyc_q   <= cyc_d;
      hi_q    <= hi_d;
    end
  end

  always_comb begin
    mem_read = '0;
    if (rst && !bad) begin
      unique case (1'b1)
        ram_hit:
          mem_read = ram_q[idx];
        sel == REG_STATUS:
          mem_read = XLEN'(status);
        sel == REG_CYC_LO:
          mem_read = XLEN'(cyc_q[31:0]);
        sel == REG_CYC_HI:
          mem_read = XLEN'(hi_q);
        default:
          mem_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_data_mem.sv
// Directed scoreboard bench for riscv_data_mem: expected
// responses are queued by stimulus and popped by a monitor.
module tb_riscv_data_mem;

  localparam logic [31:0] TXD = 32'h8000_0000;
  localparam logic [31:0] STA = 32'h8000_0004;
  localparam logic [31:0] CLO = 32'h8000_0008;
  localparam logic [31:0] CHI = 32'h8000_000C;

  logic        clk, rst, mem_write, tx_ready;
  logic        tx_valid, fault, chk_v;
  logic [31:0] mem_addr, mem_data, mem_read;
  logic [7:0]  tx_data;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       nm;
  } exp_t;

  exp_t       rd_q[$];
  logic [7:0] tx_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;

  riscv_data_mem dut (
    .clk       (clk),
    .rst       (rst),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .fault     (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic w,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic rdy);
    @(posedge clk);
    #1;
    mem_write = w;
    mem_addr  = a;
    mem_data  = d;
    tx_ready  = rdy;
    chk_v     = 1'b0;
  endtask

  // kind: 0 mem_read, 1 fault, 2 tx_valid, 3 tx_data
  task automatic want(input int k,
                      input logic [31:0] e,
                      input string nm);
    exp_t x;
    x.kind = k;
    x.exp  = e;
    x.nm   = nm;
    chk_v  = 1'b1;
    rd_q.push_back(x);
  endtask

  task automatic push_tx(input logic [7:0] b,
                         input logic rdy);
    drive(1'b1, TXD, {24'h0, b}, rdy);
    tx_q.push_back(b);
  endtask

  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    logic [7:0]  b;
    if (chk_v) begin
      n_cmp++;
      if (rd_q.size() == 0) begin
        n_bad++;
        $display("FAIL noexp: got %h want none", mem_read);
      end else begin
        e = rd_q.pop_front();
        case (e.kind)
          0:       act = mem_read;
          1:       act = {31'b0, fault};
          2:       act = {31'b0, tx_valid};
          default: act = {24'b0, tx_data};
        endcase
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL %s: got %h want %h",
                   e.nm, act, e.exp);
        end
      end
    end
    if (rst && tx_valid && tx_ready) begin
      n_cmp++;
      if (tx_q.size() == 0) begin
        n_bad++;
        $display("FAIL tx_extra: got %h want none", tx_data);
      end else begin
        b = tx_q.pop_front();
        if (tx_data !== b) begin
          n_bad++;
          $display("FAIL tx_byte: got %h want %h", tx_data, b);
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    tx_ready  = 1'b0;
    chk_v     = 1'b0;

    drive(0, STA, 0, 0); want(0, 32'h0, "rst_rd");
    drive(0, 0, 0, 0);   want(1, 32'h0, "rst_fault");
    drive(0, 0, 0, 0);   want(2, 32'h0, "rst_txv");
    drive(0, 0, 0, 0);   want(3, 32'h0, "rst_txd");
    drive(0, 0, 0, 0);
    rst = 1'b1;

    repeat (9) drive(0, 0, 0, 0);
    drive(0, CLO, 0, 0); want(0, 32'd10, "cyc_10");

    drive(1, 32'h14, 32'h1234_5678, 0);
    drive(1, 32'h10, 32'hDEAD_BEEF, 0);
    drive(0, 32'h10, 0, 0); want(0, 32'hDEAD_BEEF, "ram_rd10");
    drive(0, 32'h14, 0, 0); want(0, 32'h1234_5678, "ram_rd14");
    drive(1, 32'h10, 32'hCAFE_F00D, 0);
    want(0, 32'hDEAD_BEEF, "ram_old");
    drive(0, 32'h10, 0, 0); want(0, 32'hCAFE_F00D, "ram_new");

    drive(1, 32'h11, 32'h5555_5555, 0);
    drive(0, 32'h10, 0, 0); want(0, 32'hCAFE_F00D, "ram_unch");
    drive(0, 32'h11, 0, 0); want(0, 32'h0, "mis_rd");
    drive(0, 32'h10, 0, 0); want(1, 32'h1, "fault_set");
    drive(1, STA, 32'h100, 0);
    drive(0, 32'h10, 0, 0); want(1, 32'h0, "fault_clr");
    drive(0, 32'h4000_0000, 0, 0); want(0, 32'h0, "oor_rd");
    drive(0, 32'h10, 0, 0); want(1, 32'h1, "fault_oor");
    drive(1, STA, 32'h100, 0);

    for (int i = 0; i < 4; i++) push_tx(8'h41 + 8'(i), 0);
    drive(0, STA, 0, 0); want(0, 32'h41, "st_full");
    drive(1, TXD, 32'h45, 0);
    drive(0, STA, 0, 0); want(0, 32'h241, "st_ovf");
    repeat (4) drive(0, 0, 0, 1);
    drive(0, STA, 0, 0); want(0, 32'h202, "st_empty");
    drive(0, 0, 0, 0);   want(2, 32'h0, "txv_empty");
    drive(1, STA, 32'h200, 0);

    for (int i = 0; i < 4; i++) push_tx(8'h51 + 8'(i), 0);
    push_tx(8'h55, 1);
    drive(0, STA, 0, 0); want(0, 32'h41, "st_pp_full");
    repeat (4) drive(0, 0, 0, 1);
    push_tx(8'h66, 1);
    drive(0, STA, 0, 0); want(0, 32'h10, "st_pp_empty");
    drive(0, 0, 0, 1);
    drive(0, 0, 0, 0);

    drive(0, CLO, 0, 0);
    force dut.cyc_q = 64'h0000_0000_FFFF_FFFF;
    want(0, 32'hFFFF_FFFF, "cyc_lo");
    #1 release dut.cyc_q;
    drive(0, CHI, 0, 0); want(0, 32'h0, "cyc_hi");
    drive(0, CLO, 0, 0); want(0, 32'h1, "cyc_lo_wrap");
    drive(0, CHI, 0, 0); want(0, 32'h1, "cyc_hi_wrap");
    drive(1, CLO, 32'hAAAA, 0);
    drive(0, 0, 0, 0); want(1, 32'h0, "cyc_wr_nofault");

    drive(1, TXD, 32'h71, 0);
    drive(1, TXD, 32'h72, 0);
    drive(1, TXD, 32'h73, 0);
    drive(0, 32'h3, 0, 0);
    drive(0, 0, 0, 0); want(1, 32'h1, "pre_rst_fault");
    rst = 1'b0;
    drive(0, 0, 0, 1);
    rst = 1'b1;
    want(2, 32'h0, "rst_mid_txv");
    drive(0, 0, 0, 1);   want(1, 32'h0, "rst_mid_fault");
    drive(0, CLO, 0, 1); want(0, 32'h2, "rst_mid_cyc");
    drive(0, STA, 0, 1); want(0, 32'h2, "rst_mid_st");
    drive(0, 0, 0, 0);
    @(negedge clk);
    #1;

    n_cmp++;
    if (rd_q.size() != 0 || tx_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d/%0d left want 0/0",
               rd_q.size(), tx_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
